// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and fetch-path types for the instruction fetch master.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_ADDR = 2'b01,
        FETCH_DATA = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: registered storage, flush clears occupancy, push+pop legal when full.
module ifetch_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
        end
    end

endmodule

// File: rtl/ahb_ifetch.sv
// Non-pipelined AHB-Lite instruction fetch master feeding decode through a prefetch FIFO.
module ahb_ifetch
    import ahb_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    input  logic        inst_ready
);

    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    fetch_state_e     state;
    fetch_state_e     state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_nxt;
    logic             kill;
    logic             kill_nxt;
    logic             pop;
    logic             push;
    logic             data_done;
    logic             room;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_nxt;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    assign HWRITE = 1'b0;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HWDATA = 32'h0;

    assign inst_valid = !fifo_empty;
    assign inst_data  = head.data;
    assign inst_pc    = head.pc;
    assign inst_err   = head.err;

    // Next-state, next-PC and kill tracking; HADDR doubles as the issued PC during DATA.
    always_comb begin
        pop          = inst_valid && inst_ready && !redirect_valid;
        data_done    = (state == FETCH_DATA) && HREADY;
        push         = data_done && !kill && !redirect_valid;
        wr_entry     = '{err: (HRESP != HRESP_OKAY), pc: HADDR, data: HRDATA};
        count_nxt    = redirect_valid ? '0 : CNT_W'(fifo_count + CNT_W'(push) - CNT_W'(pop));
        room         = (count_nxt < CNT_W'(FIFO_DEPTH));
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        kill_nxt     = kill;

        case (state)
            FETCH_IDLE: begin
                if (redirect_valid || !fifo_full || pop) begin
                    state_nxt = FETCH_ADDR;
                end
            end
            FETCH_ADDR: begin
                state_nxt    = FETCH_DATA;
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
            FETCH_DATA: begin
                if (HREADY) begin
                    state_nxt = room ? FETCH_ADDR : FETCH_IDLE;
                end
            end
            default: state_nxt = FETCH_IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
            if (state != FETCH_IDLE) begin
                kill_nxt = 1'b1;
            end
        end
        if (data_done) begin
            kill_nxt = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_ADDR;
            kill     <= 1'b0;
            HTRANS   <= HTRANS_IDLE;
            HADDR    <= RESET_ADDR;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            kill     <= kill_nxt;
            HTRANS   <= (state_nxt == FETCH_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (state_nxt == FETCH_ADDR) begin
                HADDR <= fetch_pc_nxt;
            end
        end
    end

    ifetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ahb_ifetch.sv
// Scoreboard bench for ahb_ifetch: ROM slave model, stream reference model, directed and random phases.
module tb_ahb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    typedef struct {
        logic        err;
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_ready;

    int          n_cmp = 0;
    int          n_fail = 0;

    // Slave controls: 0 = always ready, 1 = random waits, 2 = three waits per transfer.
    int          hready_mode = 0;
    bit          rand_err = 0;
    logic [31:0] err_addr = 32'h1;

    ahb_ifetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .HCLK           (clk),
        .HRESETn        (rst_n),
        .HADDR          (HADDR),
        .HTRANS         (HTRANS),
        .HWRITE         (HWRITE),
        .HSIZE          (HSIZE),
        .HBURST         (HBURST),
        .HWDATA         (HWDATA),
        .HRDATA         (HRDATA),
        .HREADY         (HREADY),
        .HRESP          (HRESP),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 32'h0000_0013;
            32'h4:   rom = 32'h0040_0093;
            default: rom = {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not seen within cycle budget (t=%0t)", name, $time);
    endtask

    // ROM slave: latches the address phase, drives data and response for the following cycles.
    initial begin
        int          ws_left;
        logic [31:0] slave_addr;
        ws_left    = 0;
        slave_addr = 32'h0;
        HREADY     = 1'b1;
        HRESP      = 2'b00;
        HRDATA     = 32'h0;
        forever begin
            @(negedge clk);
            if (HTRANS == 2'b10) begin
                slave_addr = HADDR;
                ws_left    = (hready_mode == 2) ? 3 : 0;
            end
            @(posedge clk);
            #1;
            HRDATA = rom(slave_addr);
            case (hready_mode)
                1:       HREADY = ($urandom_range(0, 3) != 0);
                2: begin
                    if (ws_left > 0) begin
                        HREADY = 1'b0;
                        ws_left--;
                    end else begin
                        HREADY = 1'b1;
                    end
                end
                default: HREADY = 1'b1;
            endcase
            HRESP = ((slave_addr == err_addr) || (rand_err && $urandom_range(0, 7) == 0)) ? 2'b01 : 2'b00;
        end
    end

    // Reference model: expected word stream, next fetch address and bus-issue rule.
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] next_addr = RESET_PC;
    logic [31:0] out_addr  = 32'h0;
    bit          outstanding = 0;
    bit          killed = 0;
    bit          in_dp = 0;
    bit          exp_issue = 0;
    bit          nonseq;
    bit          done;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            next_addr   = RESET_PC;
            outstanding = 0;
            killed      = 0;
            in_dp       = 0;
            exp_issue   = 0;
            check("rst_inst_valid", 32'(inst_valid), 32'h0);
            check("rst_htrans", 32'(HTRANS), 32'h0);
        end else begin
            nonseq = (HTRANS == 2'b10);
            check("htrans", 32'(HTRANS), exp_issue ? 32'h2 : 32'h0);
            if (nonseq) begin
                check("haddr", HADDR, next_addr);
                check("issue_with_room", 32'(exp_q.size() < DEPTH), 32'h1);
                out_addr    = next_addr;
                outstanding = 1;
                killed      = 0;
                next_addr   = next_addr + 32'd4;
            end
            check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
            if (inst_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
                check("inst_err", 32'(inst_err), 32'(e.err));
            end
            done = in_dp && HREADY;
            if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (!killed && !redirect_valid) begin
                    e.err  = (HRESP != 2'b00);
                    e.pc   = out_addr;
                    e.data = rom(out_addr);
                    exp_q.push_back(e);
                end
                outstanding = 0;
            end
            in_dp = nonseq ? 1'b1 : (done ? 1'b0 : in_dp);
            if (redirect_valid) begin
                exp_q.delete();
                next_addr = redirect_pc & 32'hFFFF_FFFC;
                if (outstanding) killed = 1;
            end
            exp_issue = !outstanding && !nonseq && (exp_q.size() < DEPTH);
        end
    end

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_nonseq(input logic [31:0] a, input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (HTRANS == 2'b10 && HADDR == a) begin
                n_cmp++;
                return;
            end
        end
        bound_expired(name);
    endtask

    task automatic wait_any_nonseq(output logic [31:0] a, input bit need_valid, input string name);
        a = 32'hDEAD_BEEF;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (HTRANS == 2'b10 && (!need_valid || inst_valid)) begin
                a = HADDR;
                return;
            end
        end
        bound_expired(name);
    endtask

    initial begin
        int          n_issue;
        logic [31:0] a;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_haddr", HADDR, RESET_PC);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_err", 32'(inst_err), 32'h0);
        check("hwrite", 32'(HWRITE), 32'h0);
        check("hsize", 32'(HSIZE), 32'h2);
        check("hburst", 32'(HBURST), 32'h0);
        check("hwdata", HWDATA, 32'h0);

        // Release in cycle 0: NONSEQ in cycle 1, first word in cycle 3, second in cycle 5.
        cycle_start();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("c1_htrans", 32'(HTRANS), 32'h2);
        check("c1_haddr", HADDR, 32'h0);
        @(negedge clk);
        check("c2_valid", 32'(inst_valid), 32'h0);
        @(negedge clk);
        check("c3_valid", 32'(inst_valid), 32'h1);
        check("c3_pc", inst_pc, 32'h0);
        check("c3_data", inst_data, 32'h0000_0013);
        @(negedge clk);
        @(negedge clk);
        check("c5_valid", 32'(inst_valid), 32'h1);
        check("c5_pc", inst_pc, 32'h4);
        check("c5_data", inst_data, 32'h0040_0093);

        // Back-pressure: exactly DEPTH fetches, then one more per single-cycle ready.
        cycle_start();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle_start();
        redirect_valid = 1'b0;
        n_issue = 0;
        repeat (20) begin
            @(negedge clk);
            if (HTRANS == 2'b10) n_issue++;
            cycle_start();
        end
        check("stall_issue_count", 32'(n_issue), 32'(DEPTH));
        check("stall_head_pc", inst_pc, 32'h200);
        inst_ready = 1'b1;
        cycle_start();
        inst_ready = 1'b0;
        @(negedge clk);
        check("refill_htrans", 32'(HTRANS), 32'h2);
        check("refill_haddr", HADDR, 32'h208);
        n_issue = 0;
        repeat (10) begin
            cycle_start();
            @(negedge clk);
            if (HTRANS == 2'b10) n_issue++;
        end
        check("refill_extra_issue", 32'(n_issue), 32'h0);

        // Redirect during the DATA phase of the 0x8 fetch.
        cycle_start();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cycle_start();
        redirect_valid = 1'b0;
        wait_nonseq(32'h8, "fetch_0x8");
        cycle_start();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        cycle_start();
        redirect_valid = 1'b0;
        wait_any_nonseq(a, 1'b0, "redir_data_issue");
        check("redir_data_haddr", a, 32'h100);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (inst_valid) begin
                    seen = 1;
                    check("redir_data_first_pc", inst_pc, 32'h100);
                end else begin
                    @(negedge clk);
                end
            end
            if (!seen) bound_expired("redir_data_first_word");
        end

        // Redirect during ADDR: killed data phase, then NONSEQ to the new PC two cycles later.
        wait_nonseq(32'h108, "fetch_0x108");
        cycle_start();
        cycle_start();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        check("redir_addr_r_haddr", HADDR, 32'h10C);
        cycle_start();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_addr_r1_htrans", 32'(HTRANS), 32'h0);
        @(negedge clk);
        check("redir_addr_r2_htrans", 32'(HTRANS), 32'h2);
        check("redir_addr_r2_haddr", HADDR, 32'h300);

        // Three wait states on one transfer.
        cycle_start();
        hready_mode = 2;
        wait_any_nonseq(a, 1'b0, "wait_state_issue");
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("wait_state_htrans", 32'(HTRANS), 32'h0);
        end
        @(negedge clk);
        check("wait_state_next_haddr", HADDR, a + 32'd4);
        check("wait_state_valid", 32'(inst_valid), 32'h1);
        check("wait_state_pc", inst_pc, a);
        cycle_start();
        hready_mode = 0;

        // Error response on the 0x10 fetch.
        err_addr       = 32'h10;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        cycle_start();
        redirect_valid = 1'b0;
        wait_nonseq(32'h10, "fetch_0x10");
        @(negedge clk);
        @(negedge clk);
        check("err_valid", 32'(inst_valid), 32'h1);
        check("err_pc", inst_pc, 32'h10);
        check("err_flag", 32'(inst_err), 32'h1);
        check("err_next_htrans", 32'(HTRANS), 32'h2);
        check("err_next_haddr", HADDR, 32'h14);
        cycle_start();
        err_addr = 32'h1;

        // Randomised traffic, including redirects near the top of the address space.
        hready_mode = 1;
        rand_err    = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle_start();
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else redirect_pc = 32'($urandom_range(0, 32'h3FF));
        end
        cycle_start();
        redirect_valid = 1'b0;
        rand_err       = 1'b0;

        // Reset in the middle of a waited DATA phase with the FIFO occupied.
        hready_mode    = 2;
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        cycle_start();
        redirect_valid = 1'b0;
        wait_any_nonseq(a, 1'b1, "rst_mid_issue");
        cycle_start();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(inst_valid), 32'h0);
        check("rst_mid_htrans", 32'(HTRANS), 32'h0);
        check("rst_mid_haddr", HADDR, RESET_PC);
        hready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_restart_htrans", 32'(HTRANS), 32'h2);
        check("rst_mid_restart_haddr", HADDR, RESET_PC);
        repeat (10) cycle_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_ifetch.md
# ahb_ifetch

Instruction-fetch master for the RISC-V core's instruction bus. It drives AHB-Lite single-word read transfers into the instruction ROM slave and buffers returned words in a small prefetch FIFO. It then hands them to the decode stage with a valid/ready handshake. A redirect (branch, jump or trap) restarts fetch at a new PC, and all in-flight and buffered words are discarded.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 2: prefetch entries; power of two, 2..8.

Ports:
- HCLK, in, 1: clock; everything is on the rising edge.
- HRESETn, in, 1: asynchronous active-low reset; deassertion is synchronous to HCLK.
- HADDR, out, 32: byte address; bits [1:0] are always 00.
- HTRANS, out, 2: 2'b00 IDLE or 2'b10 NONSEQ only.
- HWRITE, out, 1: constant 0.
- HSIZE, out, 3: constant 3'b010 (word).
- HBURST, out, 3: constant 3'b000 (single).
- HWDATA, out, 32: constant 0.
- HRDATA, in, 32: read data.
- HREADY, in, 1: data-phase completion.
- HRESP, in, 2: 2'b00 OKAY; any other value is an error.
- redirect_valid, in, 1: restart fetch this cycle.
- redirect_pc, in, 32: new PC; bits [1:0] are ignored.
- inst_valid, out, 1: FIFO head valid.
- inst_data, out, 32: instruction word.
- inst_pc, out, 32: address of inst_data.
- inst_err, out, 1: the word returned with a non-OKAY HRESP.
- inst_ready, in, 1: decode accepts the head.

## Operation
- Internal state:
  - fetch_pc: next address to issue.
  - FSM: IDLE, ADDR, DATA.
  - kill flag for the current data phase.
  - FIFO storing {err, pc, data}.
- Transfers are non-pipelined; at most one transfer is outstanding.
- IDLE → ADDR when the FIFO has at least one free entry after this cycle's pop.
- ADDR (exactly one cycle):
  - Drive HTRANS=NONSEQ and HADDR=fetch_pc.
  - Latch the issued PC.
  - fetch_pc += 4, wrapping modulo 2^32.
  - Go to DATA.
- DATA:
  - Drive HTRANS=IDLE and wait for HREADY=1.
  - On that edge, push {HRESP!=00, issued PC, HRDATA} unless kill is set.
  - Go to ADDR if room remains, otherwise IDLE.
  - HREADY is ignored in every state except DATA.
- Redirect (any state):
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - FIFO is cleared and the same-cycle pop is ignored.
  - In ADDR or DATA the current transfer completes on the bus, but kill is set so its word is dropped. kill clears when that data phase completes.
  - In IDLE, the next state is ADDR.
  - A redirect in the same cycle as a DATA completion drops that word.
  - A second redirect while kill is set only updates fetch_pc.
- FIFO behaviour:
  - Pop when inst_valid && inst_ready.
  - A push and a pop in the same cycle on a full FIFO are legal.
  - inst_* show the head entry; inst_data/inst_pc are don't-care when inst_valid=0.
- An error word is delivered like any other word; fetch continues sequentially.
- Reset mid-transfer: the FSM returns to IDLE immediately and the outstanding data phase is abandoned.

## Timing
- Reset values:
  - HTRANS=IDLE, HADDR=RESET_PC.
  - inst_valid=0, inst_err=0, inst_data=0, inst_pc=0.
  - fetch_pc=RESET_PC, FSM=IDLE, FIFO empty, kill=0.
- First NONSEQ is driven in the first cycle after HRESETn deasserts.
- Against the ROM slave (HREADY=1 in the cycle after NONSEQ):
  - Address phase in cycle N, data phase in cycle N+1, inst_valid in cycle N+2.
  - Peak rate is one word every 2 cycles.
- Each HREADY=0 cycle during DATA adds one cycle of latency.
- Redirect in cycle R with FSM IDLE: NONSEQ to the new PC in cycle R+1.
- Redirect in cycle R during ADDR: the kill data phase follows in cycle R+1 with no new issue, then NONSEQ to the new PC in cycle R+2.
- inst_valid and inst_pc are never combinationally dependent on inst_ready or redirect_valid.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ.
  - HSIZE_WORD, HBURST_SINGLE.
  - HRESP_OKAY.
  - Fetch FSM state enum.
- Sub-module ifetch_fifo:
  - Parameterised synchronous FIFO of width 65 and depth FIFO_DEPTH.
  - Ports: flush, push, pop, full, empty, count.
  - Async active-low reset.
- Top level holds the FSM, fetch_pc, kill flag and AHB output drive.

## Test plan
- Reset release, ROM returning 32'h0000_0013 at 0x0 and 32'h0040_0093 at 0x4, inst_ready=1: NONSEQ at 0x0 in cycle 1, inst_valid in cycle 3 with pc=0x0; second word pc=0x4 in cycle 5.
- inst_ready=0, FIFO_DEPTH=2: exactly two NONSEQ issued, then HTRANS stays IDLE. Raising inst_ready for one cycle gives exactly one new NONSEQ on the next cycle.
- Redirect to 0x0000_0102 asserted during DATA of the 0x8 fetch: the 0x8 word is never presented; next NONSEQ HADDR=0x0000_0100; the first inst_pc after that is 0x100.
- Slave inserts 3 HREADY=0 wait cycles: HTRANS stays IDLE throughout, the word is captured on the HREADY=1 edge, and the PC sequence is unchanged.
- HRESP=2'b01 with HREADY=1 on the fetch of 0x10: a word is delivered with inst_err=1 and inst_pc=0x10; the next fetch is at 0x14.
- HRESETn pulsed low mid-DATA with the FIFO holding 2 entries: inst_valid=0 immediately; after release, NONSEQ at RESET_PC.
